// File: rtl/bu_pkg.sv
// Shared types for the branch unit: compare opcodes, queue-entry layout and funct3 decode.
// Struct fields are sized by the BU_* widths; module parameters must not exceed them.
package bu_pkg;

    localparam int BU_DATA_WIDTH = 64;
    localparam int BU_ADDR_WIDTH = 64;
    localparam int BU_TAG_WIDTH  = 3;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    typedef enum logic [2:0] {
        EQ,
        NE,
        LT,
        GE,
        LTU,
        GEU,
        NONE
    } cmp_op_t;

    typedef enum logic [1:0] {
        ST_FREE,
        ST_WAIT,
        ST_READY
    } brq_state_t;

    typedef struct packed {
        logic [BU_TAG_WIDTH-1:0]  tag;
        cmp_op_t                  op;
        logic [BU_ADDR_WIDTH-1:0] pc;
        logic [BU_ADDR_WIDTH-1:0] imm;
        logic                     pred;
        logic [BU_DATA_WIDTH-1:0] j_value;
        logic                     j_virtual;
        logic [BU_TAG_WIDTH-1:0]  j_tag;
        logic [BU_DATA_WIDTH-1:0] k_value;
        logic                     k_virtual;
        logic [BU_TAG_WIDTH-1:0]  k_tag;
    } brq_entry_t;

    // funct3 values 2 and 3 are not branches; NONE makes them resolve not-taken
    function automatic cmp_op_t decode_funct3(input logic [2:0] funct3);
        case (funct3)
            F3_BEQ:  return EQ;
            F3_BNE:  return NE;
            F3_BLT:  return LT;
            F3_BGE:  return GE;
            F3_BLTU: return LTU;
            F3_BGEU: return GEU;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluation and target selection.
module branch_cmp
    import bu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  cmp_op_t               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] imm,
    output logic                  taken,
    output logic [ADDR_WIDTH-1:0] target
);

    always_comb begin
        taken = 1'b0;
        case (op)
            EQ:      taken = (a == b);
            NE:      taken = (a != b);
            LT:      taken = ($signed(a) < $signed(b));
            GE:      taken = ($signed(a) >= $signed(b));
            LTU:     taken = (a < b);
            GEU:     taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

    // Both sums wrap at ADDR_WIDTH
    assign target = taken ? (pc + imm) : (pc + ADDR_WIDTH'(4));

endmodule

// File: rtl/branch_resolve_queue.sv
// Oldest-first branch resolve queue with CDB operand capture and mispredict squash.
// Optional BRQ_PERF_CNT_EN adds resolved/mispredicted event counters.
module branch_resolve_queue
    import bu_pkg::*;
#(
    parameter int DATA_WIDTH = BU_DATA_WIDTH,
    parameter int ADDR_WIDTH = BU_ADDR_WIDTH,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = BU_TAG_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [TAG_WIDTH-1:0]    issue_tag,
    input  logic [2:0]              issue_funct3,
    input  logic [ADDR_WIDTH-1:0]   issue_pc,
    input  logic [ADDR_WIDTH-1:0]   issue_imm,
    input  logic                    issue_pred_taken,
    input  logic [DATA_WIDTH-1:0]   issue_j_value,
    input  logic [DATA_WIDTH-1:0]   issue_k_value,
    input  logic                    issue_j_virtual,
    input  logic                    issue_k_virtual,
    input  logic [TAG_WIDTH-1:0]    issue_j_tag,
    input  logic [TAG_WIDTH-1:0]    issue_k_tag,
    input  logic                    CDB_valid,
    input  logic [DATA_WIDTH-1:0]   CDB_result,
    input  logic [TAG_WIDTH-1:0]    CDB_rs_id,
    input  logic                    flush,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [TAG_WIDTH-1:0]    result_tag,
    output logic                    result_taken,
    output logic [ADDR_WIDTH-1:0]   result_target,
    output logic                    result_mispredict,
    output logic                    Busy,
    output logic [$clog2(DEPTH):0]  count
`ifdef BRQ_PERF_CNT_EN
    ,
    output logic [31:0]             perf_resolved,
    output logic [31:0]             perf_mispredicted
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    brq_entry_t entries [DEPTH];
    brq_state_t state   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic                  head_taken;
    logic [ADDR_WIDTH-1:0] head_target;

    logic out_accept;
    logic squash;
    logic issue_fire;
    logic deq_fire;
    logic issue_j_hit;
    logic issue_k_hit;
    logic [DEPTH-1:0] j_hit;
    logic [DEPTH-1:0] k_hit;
    brq_entry_t new_entry;

    branch_cmp #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_cmp (
        .op     (entries[head].op),
        .a      (entries[head].j_value[DATA_WIDTH-1:0]),
        .b      (entries[head].k_value[DATA_WIDTH-1:0]),
        .pc     (entries[head].pc[ADDR_WIDTH-1:0]),
        .imm    (entries[head].imm[ADDR_WIDTH-1:0]),
        .taken  (head_taken),
        .target (head_target)
    );

    assign out_accept  = result_valid && result_ready;
    assign squash      = out_accept && result_mispredict;
    assign issue_ready = (count != CNT_W'(DEPTH)) && !squash;
    assign issue_fire  = issue_valid && issue_ready;
    // A squashing result also kills the head, so it must not advance into the output register
    assign deq_fire    = (state[head] == ST_READY) && (!result_valid || result_ready) && !squash;
    assign Busy        = (count != '0) || result_valid;

    assign issue_j_hit = issue_j_virtual && CDB_valid && (CDB_rs_id == issue_j_tag);
    assign issue_k_hit = issue_k_virtual && CDB_valid && (CDB_rs_id == issue_k_tag);

    always_comb begin
        new_entry           = '0;
        new_entry.tag       = BU_TAG_WIDTH'(issue_tag);
        new_entry.op        = decode_funct3(issue_funct3);
        new_entry.pc        = BU_ADDR_WIDTH'(issue_pc);
        new_entry.imm       = BU_ADDR_WIDTH'(issue_imm);
        new_entry.pred      = issue_pred_taken;
        new_entry.j_value   = BU_DATA_WIDTH'(issue_j_hit ? CDB_result : issue_j_value);
        new_entry.j_virtual = issue_j_virtual && !issue_j_hit;
        new_entry.j_tag     = BU_TAG_WIDTH'(issue_j_tag);
        new_entry.k_value   = BU_DATA_WIDTH'(issue_k_hit ? CDB_result : issue_k_value);
        new_entry.k_virtual = issue_k_virtual && !issue_k_hit;
        new_entry.k_tag     = BU_TAG_WIDTH'(issue_k_tag);
    end

    always_comb begin
        j_hit = '0;
        k_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            j_hit[i] = (state[i] == ST_WAIT) && entries[i].j_virtual && CDB_valid &&
                       (entries[i].j_tag[TAG_WIDTH-1:0] == CDB_rs_id);
            k_hit[i] = (state[i] == ST_WAIT) && entries[i].k_virtual && CDB_valid &&
                       (entries[i].k_tag[TAG_WIDTH-1:0] == CDB_rs_id);
        end
    end

    // Later assignments win: capture, then dequeue, then issue, then squash clears everything
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                state[i]   <= ST_FREE;
                entries[i] <= '0;
            end
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            result_valid      <= 1'b0;
            result_tag        <= '0;
            result_taken      <= 1'b0;
            result_target     <= '0;
            result_mispredict <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (j_hit[i]) begin
                    entries[i].j_value   <= BU_DATA_WIDTH'(CDB_result);
                    entries[i].j_virtual <= 1'b0;
                end
                if (k_hit[i]) begin
                    entries[i].k_value   <= BU_DATA_WIDTH'(CDB_result);
                    entries[i].k_virtual <= 1'b0;
                end
                if ((state[i] == ST_WAIT) &&
                    (!entries[i].j_virtual || j_hit[i]) &&
                    (!entries[i].k_virtual || k_hit[i])) begin
                    state[i] <= ST_READY;
                end
            end

            if (deq_fire) begin
                state[head]       <= ST_FREE;
                head              <= head + PTR_W'(1);
                result_valid      <= 1'b1;
                result_tag        <= entries[head].tag[TAG_WIDTH-1:0];
                result_taken      <= head_taken;
                result_target     <= head_target;
                result_mispredict <= (head_taken != entries[head].pred);
            end else if (out_accept) begin
                result_valid <= 1'b0;
            end

            if (issue_fire) begin
                entries[tail] <= new_entry;
                state[tail]   <= (new_entry.j_virtual || new_entry.k_virtual) ? ST_WAIT : ST_READY;
                tail          <= tail + PTR_W'(1);
            end

            case ({issue_fire, deq_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (squash) begin
                for (int i = 0; i < DEPTH; i++) begin
                    state[i] <= ST_FREE;
                end
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end
        end
    end

`ifdef BRQ_PERF_CNT_EN
    // Event counters survive flush so software can read totals across pipeline squashes
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_resolved     <= '0;
            perf_mispredicted <= '0;
        end else if (out_accept) begin
            perf_resolved <= perf_resolved + 32'd1;
            if (result_mispredict) begin
                perf_mispredicted <= perf_mispredicted + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (default DEPTH=4, 64-bit datapath).
module tb_branch_resolve_queue;
    import bu_pkg::*;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int TW = 3;

    logic          clk;
    logic          rst;
    logic          issue_valid;
    logic          issue_ready;
    logic [TW-1:0] issue_tag;
    logic [2:0]    issue_funct3;
    logic [AW-1:0] issue_pc;
    logic [AW-1:0] issue_imm;
    logic          issue_pred_taken;
    logic [DW-1:0] issue_j_value;
    logic [DW-1:0] issue_k_value;
    logic          issue_j_virtual;
    logic          issue_k_virtual;
    logic [TW-1:0] issue_j_tag;
    logic [TW-1:0] issue_k_tag;
    logic          CDB_valid;
    logic [DW-1:0] CDB_result;
    logic [TW-1:0] CDB_rs_id;
    logic          flush;
    logic          result_valid;
    logic          result_ready;
    logic [TW-1:0] result_tag;
    logic          result_taken;
    logic [AW-1:0] result_target;
    logic          result_mispredict;
    logic          Busy;
    logic [2:0]    count;
`ifdef BRQ_PERF_CNT_EN
    logic [31:0]   perf_resolved;
    logic [31:0]   perf_mispredicted;
`endif

    int checks;
    int errors;

    branch_resolve_queue dut (
        .clk               (clk),
        .rst               (rst),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .issue_tag         (issue_tag),
        .issue_funct3      (issue_funct3),
        .issue_pc          (issue_pc),
        .issue_imm         (issue_imm),
        .issue_pred_taken  (issue_pred_taken),
        .issue_j_value     (issue_j_value),
        .issue_k_value     (issue_k_value),
        .issue_j_virtual   (issue_j_virtual),
        .issue_k_virtual   (issue_k_virtual),
        .issue_j_tag       (issue_j_tag),
        .issue_k_tag       (issue_k_tag),
        .CDB_valid         (CDB_valid),
        .CDB_result        (CDB_result),
        .CDB_rs_id         (CDB_rs_id),
        .flush             (flush),
        .result_valid      (result_valid),
        .result_ready      (result_ready),
        .result_tag        (result_tag),
        .result_taken      (result_taken),
        .result_target     (result_target),
        .result_mispredict (result_mispredict),
        .Busy              (Busy),
        .count             (count)
`ifdef BRQ_PERF_CNT_EN
        ,
        .perf_resolved     (perf_resolved),
        .perf_mispredicted (perf_mispredicted)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1-2 time units after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic [TW-1:0] tag, input logic [2:0] f3,
                               input logic [AW-1:0] pc, input logic [AW-1:0] imm,
                               input logic pred, input logic [DW-1:0] jv,
                               input logic [DW-1:0] kv);
        issue_valid      = 1'b1;
        issue_tag        = tag;
        issue_funct3     = f3;
        issue_pc         = pc;
        issue_imm        = imm;
        issue_pred_taken = pred;
        issue_j_value    = jv;
        issue_k_value    = kv;
        issue_j_virtual  = 1'b0;
        issue_k_virtual  = 1'b0;
        issue_j_tag      = '0;
        issue_k_tag      = '0;
    endtask

    task automatic idle_issue();
        issue_valid     = 1'b0;
        issue_j_virtual = 1'b0;
        issue_k_virtual = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        #1;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_result_valid: got %0b want 0", result_valid); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_issue_ready: got %0b want 1", issue_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", Busy); end
        checks++; if (result_target !== 64'h0) begin errors++; $display("[TB] FAIL reset_target: got %0h want 0", result_target); end
    endtask

    task automatic test_beq();
        result_ready = 1'b1;
        drive_issue(3'd1, F3_BEQ, 64'h1000, 64'h40, 1'b0, 64'd5, 64'd5);
        step();
        idle_issue();
        #1;
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL beq_count_queued: got %0d want 1", count); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL beq_not_yet_valid: got %0b want 0", result_valid); end
        step();
        #1;
        checks++; if (result_valid !== 1'b1) begin errors++; $display("[TB] FAIL beq_valid: got %0b want 1", result_valid); end
        checks++; if (result_tag !== 3'd1) begin errors++; $display("[TB] FAIL beq_tag: got %0d want 1", result_tag); end
        checks++; if (result_taken !== 1'b1) begin errors++; $display("[TB] FAIL beq_taken: got %0b want 1", result_taken); end
        checks++; if (result_target !== 64'h1040) begin errors++; $display("[TB] FAIL beq_target: got %0h want 1040", result_target); end
        checks++; if (result_mispredict !== 1'b1) begin errors++; $display("[TB] FAIL beq_mispredict: got %0b want 1", result_mispredict); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL beq_squash_issue_ready: got %0b want 0", issue_ready); end
        step();
        #1;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL beq_consumed: got %0b want 0", result_valid); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL beq_issue_ready_back: got %0b want 1", issue_ready); end
    endtask

    task automatic test_signed_unsigned();
        result_ready = 1'b1;
        drive_issue(3'd2, F3_BLT, 64'h2000, 64'h10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        step();
        drive_issue(3'd3, F3_BLTU, 64'h2000, 64'h10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        step();
        idle_issue();
        #1;
        checks++; if (result_valid !== 1'b1 || result_tag !== 3'd2) begin errors++; $display("[TB] FAIL blt_present: got valid=%0b tag=%0d want valid=1 tag=2", result_valid, result_tag); end
        checks++; if (result_taken !== 1'b1) begin errors++; $display("[TB] FAIL blt_taken: got %0b want 1", result_taken); end
        checks++; if (result_target !== 64'h2010) begin errors++; $display("[TB] FAIL blt_target: got %0h want 2010", result_target); end
        checks++; if (result_mispredict !== 1'b0) begin errors++; $display("[TB] FAIL blt_mispredict: got %0b want 0", result_mispredict); end
        step();
        #1;
        checks++; if (result_valid !== 1'b1 || result_tag !== 3'd3) begin errors++; $display("[TB] FAIL bltu_present: got valid=%0b tag=%0d want valid=1 tag=3", result_valid, result_tag); end
        checks++; if (result_taken !== 1'b0) begin errors++; $display("[TB] FAIL bltu_taken: got %0b want 0", result_taken); end
        checks++; if (result_target !== 64'h2004) begin errors++; $display("[TB] FAIL bltu_target: got %0h want 2004", result_target); end
        checks++; if (result_mispredict !== 1'b0) begin errors++; $display("[TB] FAIL bltu_mispredict: got %0b want 0", result_mispredict); end
        step();
        // funct3=2 is not a branch and must resolve not-taken even with equal operands
        drive_issue(3'd6, 3'd2, 64'h2800, 64'h100, 1'b0, 64'd9, 64'd9);
        step();
        idle_issue();
        step();
        #1;
        checks++; if (result_valid !== 1'b1 || result_taken !== 1'b0) begin errors++; $display("[TB] FAIL f3_2_not_taken: got valid=%0b taken=%0b want 1/0", result_valid, result_taken); end
        checks++; if (result_target !== 64'h2804) begin errors++; $display("[TB] FAIL f3_2_target: got %0h want 2804", result_target); end
        step();
    endtask

    task automatic test_bypass();
        result_ready = 1'b1;
        drive_issue(3'd4, F3_BEQ, 64'h3000, 64'h8, 1'b1, 64'h99, 64'd7);
        issue_j_virtual = 1'b1;
        issue_j_tag     = 3'd3;
        CDB_valid       = 1'b1;
        CDB_rs_id       = 3'd3;
        CDB_result      = 64'd7;
        step();
        idle_issue();
        CDB_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL bypass_count: got %0d want 1", count); end
        step();
        #1;
        checks++; if (result_valid !== 1'b1 || result_tag !== 3'd4) begin errors++; $display("[TB] FAIL bypass_present: got valid=%0b tag=%0d want 1/4", result_valid, result_tag); end
        checks++; if (result_taken !== 1'b1) begin errors++; $display("[TB] FAIL bypass_taken: got %0b want 1", result_taken); end
        checks++; if (result_target !== 64'h3008) begin errors++; $display("[TB] FAIL bypass_target: got %0h want 3008", result_target); end
        step();
    endtask

    task automatic test_cdb_wait();
        result_ready = 1'b1;
        drive_issue(3'd5, F3_BNE, 64'h5000, 64'h20, 1'b1, 64'd1, 64'h0);
        issue_k_virtual = 1'b1;
        issue_k_tag     = 3'd6;
        step();
        idle_issue();
        CDB_valid  = 1'b1;
        CDB_rs_id  = 3'd2;
        CDB_result = 64'd1;
        step();
        CDB_valid = 1'b0;
        step();
        #1;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_stalls: got %0b want 0", result_valid); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("[TB] FAIL wait_busy: got %0b want 1", Busy); end
        CDB_valid  = 1'b1;
        CDB_rs_id  = 3'd6;
        CDB_result = 64'd2;
        step();
        CDB_valid = 1'b0;
        step();
        #1;
        checks++; if (result_valid !== 1'b1 || result_taken !== 1'b1) begin errors++; $display("[TB] FAIL wait_resolved: got valid=%0b taken=%0b want 1/1", result_valid, result_taken); end
        checks++; if (result_target !== 64'h5020) begin errors++; $display("[TB] FAIL wait_target: got %0h want 5020", result_target); end
        step();
    endtask

    task automatic test_fill_drain();
        result_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_issue(TW'(i), F3_BEQ, 64'(64'h100 * (i + 1)), 64'h20, 1'b1, 64'd0, 64'd0);
            step();
        end
        idle_issue();
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL fill_count: got %0d want 4", count); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_issue_ready: got %0b want 0", issue_ready); end
        checks++; if (result_valid !== 1'b1 || result_tag !== 3'd0) begin errors++; $display("[TB] FAIL fill_head_out: got valid=%0b tag=%0d want 1/0", result_valid, result_tag); end
        drive_issue(3'd7, F3_BEQ, 64'h9000, 64'h4, 1'b1, 64'd0, 64'd0);
        step();
        idle_issue();
        #1;
        checks++; if (count !== 3'd4 || result_tag !== 3'd0) begin errors++; $display("[TB] FAIL fill_hold: got count=%0d tag=%0d want 4/0", count, result_tag); end
        result_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (result_valid !== 1'b1 || result_tag !== TW'(i) || result_target !== 64'(64'h100 * (i + 1) + 64'h20)) begin
                errors++;
                $display("[TB] FAIL drain_order_%0d: got valid=%0b tag=%0d target=%0h want 1/%0d/%0h",
                         i, result_valid, result_tag, result_target, i, 64'h100 * (i + 1) + 64'h20);
            end
            step();
        end
        #1;
        checks++; if (result_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("[TB] FAIL drain_empty: got valid=%0b count=%0d want 0/0", result_valid, count); end
    endtask

    task automatic test_squash();
        result_ready = 1'b0;
        drive_issue(3'd1, F3_BEQ, 64'h4000, 64'h40, 1'b1, 64'd1, 64'd2);
        step();
        drive_issue(3'd2, F3_BEQ, 64'h4100, 64'h40, 1'b1, 64'd3, 64'd3);
        step();
        idle_issue();
        #1;
        checks++; if (result_valid !== 1'b1 || result_mispredict !== 1'b1 || result_target !== 64'h4004) begin errors++; $display("[TB] FAIL squash_older: got valid=%0b mp=%0b target=%0h want 1/1/4004", result_valid, result_mispredict, result_target); end
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL squash_younger_queued: got %0d want 1", count); end
        result_ready = 1'b1;
        drive_issue(3'd5, F3_BEQ, 64'h4200, 64'h40, 1'b1, 64'd0, 64'd0);
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL squash_issue_ready: got %0b want 0", issue_ready); end
        step();
        idle_issue();
        #1;
        checks++; if (result_valid !== 1'b0 || count !== 3'd0 || Busy !== 1'b0) begin errors++; $display("[TB] FAIL squash_cleared: got valid=%0b count=%0d busy=%0b want 0/0/0", result_valid, count, Busy); end
        step();
        step();
        #1;
        checks++; if (result_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("[TB] FAIL squash_no_ghost: got valid=%0b count=%0d want 0/0", result_valid, count); end
    endtask

    task automatic test_flush();
        result_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_issue(TW'(i + 1), F3_BNE, 64'h6000, 64'h10, 1'b0, 64'd1, 64'd1);
            step();
        end
        idle_issue();
        #1;
        checks++; if (count !== 3'd3 || result_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre: got count=%0d valid=%0b want 3/1", count, result_valid); end
        flush = 1'b1;
        drive_issue(3'd7, F3_BEQ, 64'h7000, 64'h10, 1'b0, 64'd0, 64'd0);
        step();
        flush = 1'b0;
        idle_issue();
        #1;
        checks++; if (result_valid !== 1'b0 || count !== 3'd0 || Busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_cleared: got valid=%0b count=%0d busy=%0b want 0/0/0", result_valid, count, Busy); end
        checks++; if (result_tag !== 3'd0 || result_target !== 64'h0 || issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_outputs: got tag=%0d target=%0h ready=%0b want 0/0/1", result_tag, result_target, issue_ready); end
        step();
        step();
        #1;
        checks++; if (result_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("[TB] FAIL flush_issue_dropped: got valid=%0b count=%0d want 0/0", result_valid, count); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        flush        = 1'b0;
        result_ready = 1'b0;
        CDB_valid    = 1'b0;
        CDB_result   = '0;
        CDB_rs_id    = '0;
        drive_issue(3'd0, F3_BEQ, 64'h0, 64'h0, 1'b0, 64'd0, 64'd0);
        idle_issue();

        test_reset();
        test_beq();
        test_signed_unsigned();
        test_bypass();
        test_cdb_wait();
        test_fill_drain();
        test_squash();
        test_flush();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
